ex_dcache_req: RTL and testbench
================================

Name: ex_dcache_req

Overview:
- EX-stage data-cache request issuer; sits directly upstream of the MEM stage.
- Latches the memory-op fields of the instruction entering EX and drives the request/address handshake to the data cache.
- Produces the per-instruction "request sent" flag and the one-cycle "request accepted this clock" pulse consumed by MEM.
- Tracks the number of accepted requests whose data_ok has not yet returned, and throttles new requests on that count.

Parameters:
- MAX_INFLIGHT, 2, maximum accepted-but-not-data_ok requests; counter width is 2 bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pre_to_now_valid_i  in  1  ID->EX instruction valid
- mem_req_i  in  1  instruction is a load or store
- mem_we_i  in  1  1 = store
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word
- mem_addr_i  in  32  effective address
- mem_wdata_i  in  32  store data, low-aligned
- excep_i  in  1  instruction already carries an exception; no request is issued
- next_allowin_i  in  1  MEM allowin
- excep_flush_i  in  1  exception flush
- cache_addr_ok_i  in  1  cache accepted request
- cache_data_ok_i  in  1  cache returned or finished one request
- cache_req_o  out  1  request valid
- cache_we_o  out  1  write
- cache_size_o  out  2  size
- cache_wstrb_o  out  4  byte strobes
- cache_addr_o  out  32  address
- cache_wdata_o  out  32  replicated store data
- now_clk_pre_cache_req_o  out  1  cache_req_o & cache_addr_ok_i this cycle
- sent_req_o  out  1  current EX instruction has an accepted request; travels to MEM
- now_allowin_o  out  1  EX can accept a new instruction
- now_to_next_valid_o  out  1  EX->MEM valid
- inflight_num_o  out  2  outstanding accepted requests
- error_o  out  1  sticky protocol error

Behaviour:
- Reset values: valid = 0, state = IDLE, inflight = 0, error = 0; all outputs 0.
- Op fields latch on rising clk when now_allowin_o = 1.
- valid <= excep_flush_i ? 0 : (now_allowin_o ? pre_to_now_valid_i : valid).
- need_req = valid & mem_req & ~excep.
- States:
  - IDLE: no request outstanding for the current instruction.
  - REQ: cache_req_o held.
  - SENT: accepted, waiting for MEM allowin.
- cache_req_o = need_req & ~excep_flush_i & state != SENT & inflight < MAX_INFLIGHT. The output is combinational, so a request can issue in the first EX cycle.
  - Throttle uses the registered count only. A same-cycle data_ok does not unblock it.
- Transitions:
  - IDLE -> REQ when cache_req_o & ~cache_addr_ok_i.
  - IDLE or REQ -> SENT when req & addr_ok & ~next_allowin_i.
  - Any state -> IDLE on handoff (now_to_next_valid_o & next_allowin_i) or on excep_flush_i.
- Held request: while in REQ, address, size, strobes and data are stable; they come from the latched fields.
- Flush withdrawal: excep_flush_i in REQ without addr_ok deasserts req the same cycle and discards the request. The cache permits this withdrawal.
- Flush with acceptance: if addr_ok coincides with a flush, req was already 0, so no acceptance can occur.
  - A request accepted in an earlier cycle is still counted; its data is cancelled by MEM.
- sent_req_o = (state == SENT) | now_clk_pre_cache_req_o.
- now_to_next_valid_o = valid & ~excep_flush_i & (~need_req | sent_req_o).
- now_allowin_o = ~valid | (now_to_next_valid_o & next_allowin_i).
- inflight update, applied when the result stays within 0..MAX:
  - +1 on now_clk_pre_cache_req_o.
  - -1 on cache_data_ok_i.
  - Unchanged when both occur.
  - Unaffected by flush.
- error_o sets and holds until reset if either occurs:
  - data_ok with inflight = 0 and no acceptance;
  - increment while inflight = MAX.
- Strobes:
  - byte: 1 << addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
  - Loads drive 0000.
  - Misaligned access is excluded upstream via excep_i.
- wdata replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: as is.
- Reset mid-operation: all state clears immediately. Any request in flight is the cache's responsibility.

Test Plan:
- Store word, addr 0x1000_0004, addr_ok in same cycle, next_allowin = 1 -> one-cycle req, wstrb 1111, now_clk_pre_cache_req_o = 1, sent_req_o = 1, handoff in that cycle, inflight 0 -> 1.
- Store byte, addr 0x...03, wdata 0xAB -> wstrb 1000, wdata 0xABABABAB. Half at addr 0x...02 -> wstrb 1100.
- Load with addr_ok delayed 3 cycles -> req held 4 cycles with stable addr, state REQ; now_allowin_o = 0 until acceptance.
- inflight = 2, new load in EX -> cache_req_o = 0. data_ok arrives -> req asserts the following cycle.
- Flush during REQ (no addr_ok) -> req = 0 the same cycle, valid = 0 next cycle, inflight unchanged. Flush with inflight = 1 -> later data_ok takes it to 0, error_o stays 0.
- data_ok with inflight = 0 -> error_o = 1 next cycle and stays 1. Reset asserted mid-REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_dcache_req.sv
// ex_dcache_req: EX-stage data-cache request issuer.
//
// Latches the memory-op fields of the instruction entering EX and drives the
// req/addr_ok handshake towards the data cache. Tracks accepted requests that
// are still waiting for data_ok and throttles new requests on that count.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pre_to_now_valid_i        ID->EX instruction valid
//   mem_req_i/we_i/size_i     memory-op kind, store flag, access size
//   mem_addr_i, mem_wdata_i   effective address, low-aligned store data
//   excep_i                   instruction already faulted: no request
//   next_allowin_i            MEM can take the instruction
//   excep_flush_i             pipeline flush
//   cache_addr_ok_i           cache accepted the request this cycle
//   cache_data_ok_i           cache completed one earlier request
//   cache_req_o .. wdata_o    request channel to the cache
//   now_clk_pre_cache_req_o   request accepted this clock
//   sent_req_o                current instruction owns an accepted request
//   now_allowin_o             EX can accept a new instruction
//   now_to_next_valid_o       EX->MEM valid
//   inflight_num_o            outstanding accepted requests
//   error_o                   sticky protocol error
module ex_dcache_req #(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_to_now_valid_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        excep_i,
    input  logic        next_allowin_i,
    input  logic        excep_flush_i,
    input  logic        cache_addr_ok_i,
    input  logic        cache_data_ok_i,
    output logic        cache_req_o,
    output logic        cache_we_o,
    output logic [1:0]  cache_size_o,
    output logic [3:0]  cache_wstrb_o,
    output logic [31:0] cache_addr_o,
    output logic [31:0] cache_wdata_o,
    output logic        now_clk_pre_cache_req_o,
    output logic        sent_req_o,
    output logic        now_allowin_o,
    output logic        now_to_next_valid_o,
    output logic [1:0]  inflight_num_o,
    output logic        error_o
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SENT = 2'd2
    } state_t;

    // Byte strobes for a store; loads never write.
    function automatic logic [3:0] calc_wstrb(input logic we, input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'b0000;
        if (we) begin
            case (size)
                2'd0:    strb = 4'b0001 << addr_lo;
                2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                2'd2:    strb = 4'b1111;
                default: strb = 4'b0000;
            endcase
        end else begin
            strb = 4'b0000;
        end
        return strb;
    endfunction

    // Replicate low-aligned store data across every byte lane it may hit.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        rep = data;
        case (size)
            2'd0:    rep = {4{data[7:0]}};
            2'd1:    rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    logic        valid_q, valid_d;
    logic        req_q, we_q, excep_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    state_t      state_q, state_d;
    logic [1:0]  inflight_q, inflight_d;
    logic        error_q, error_d;

    logic need_req_s, cache_req_s, accept_s, sent_s, to_next_s, allowin_s, handoff_s;

    // Handshake and pipeline-control terms.
    always_comb begin
        need_req_s  = valid_q & req_q & ~excep_q;
        // Throttle on the registered count only; a same-cycle data_ok does not help.
        cache_req_s = need_req_s & ~excep_flush_i & (state_q != SENT) & (inflight_q < MAX_CNT);
        accept_s    = cache_req_s & cache_addr_ok_i;
        sent_s      = (state_q == SENT) | accept_s;
        to_next_s   = valid_q & ~excep_flush_i & (~need_req_s | sent_s);
        handoff_s   = to_next_s & next_allowin_i;
        allowin_s   = ~valid_q | handoff_s;
    end

    // Request FSM next state.
    always_comb begin
        state_d = state_q;
        if (excep_flush_i || handoff_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cache_req_s && !cache_addr_ok_i) begin
                        state_d = REQ;
                    end else if (accept_s && !next_allowin_i) begin
                        state_d = SENT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (accept_s && !next_allowin_i) begin
                        state_d = SENT;
                    end else begin
                        state_d = REQ;
                    end
                end
                SENT:    state_d = SENT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Valid bit, outstanding counter and sticky error next state.
    always_comb begin
        valid_d    = valid_q;
        inflight_d = inflight_q;
        error_d    = error_q;
        if (excep_flush_i) begin
            valid_d = 1'b0;
        end else if (allowin_s) begin
            valid_d = pre_to_now_valid_i;
        end else begin
            valid_d = valid_q;
        end
        // Counter ignores flush: an already accepted request still returns data_ok.
        if (accept_s && !cache_data_ok_i) begin
            if (inflight_q < MAX_CNT) begin
                inflight_d = inflight_q + 2'd1;
            end else begin
                error_d = 1'b1;
            end
        end else if (cache_data_ok_i && !accept_s) begin
            if (inflight_q != 2'd0) begin
                inflight_d = inflight_q - 2'd1;
            end else begin
                error_d = 1'b1;
            end
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            state_q    <= IDLE;
            inflight_q <= 2'd0;
            error_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            inflight_q <= inflight_d;
            error_q    <= error_d;
        end
    end

    // Op-field latch; held while EX is stalled so a pending request stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            excep_q <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (allowin_s) begin
            req_q   <= mem_req_i;
            we_q    <= mem_we_i;
            excep_q <= excep_i;
            size_q  <= mem_size_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
        end
    end

    assign cache_req_o             = cache_req_s;
    assign cache_we_o              = we_q;
    assign cache_size_o            = size_q;
    assign cache_wstrb_o           = calc_wstrb(we_q, size_q, addr_q[1:0]);
    assign cache_addr_o            = addr_q;
    assign cache_wdata_o           = calc_wdata(size_q, wdata_q);
    assign now_clk_pre_cache_req_o = accept_s;
    assign sent_req_o              = sent_s;
    assign now_allowin_o           = allowin_s;
    assign now_to_next_valid_o     = to_next_s;
    assign inflight_num_o          = inflight_q;
    assign error_o                 = error_q;

endmodule

// File: tb/tb_ex_dcache_req.sv
// Directed testbench for ex_dcache_req.
module tb_ex_dcache_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        pre_to_now_valid_i, mem_req_i, mem_we_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        excep_i, next_allowin_i, excep_flush_i, cache_addr_ok_i, cache_data_ok_i;
    logic        cache_req_o, cache_we_o;
    logic [1:0]  cache_size_o;
    logic [3:0]  cache_wstrb_o;
    logic [31:0] cache_addr_o, cache_wdata_o;
    logic        now_clk_pre_cache_req_o, sent_req_o, now_allowin_o, now_to_next_valid_o;
    logic [1:0]  inflight_num_o;
    logic        error_o;

    int checks = 0;
    int failures = 0;

    ex_dcache_req #(.MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst),
        .pre_to_now_valid_i(pre_to_now_valid_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .excep_i(excep_i), .next_allowin_i(next_allowin_i), .excep_flush_i(excep_flush_i),
        .cache_addr_ok_i(cache_addr_ok_i), .cache_data_ok_i(cache_data_ok_i),
        .cache_req_o(cache_req_o), .cache_we_o(cache_we_o), .cache_size_o(cache_size_o),
        .cache_wstrb_o(cache_wstrb_o), .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
        .now_clk_pre_cache_req_o(now_clk_pre_cache_req_o), .sent_req_o(sent_req_o),
        .now_allowin_o(now_allowin_o), .now_to_next_valid_o(now_to_next_valid_o),
        .inflight_num_o(inflight_num_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to EX (EX must be empty) and clock it in.
    task automatic load_instr(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        pre_to_now_valid_i = 1'b1; mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size;
        mem_addr_i = addr; mem_wdata_i = wdata; excep_i = 1'b0;
        cache_addr_ok_i = 1'b0; cache_data_ok_i = 1'b0; excep_flush_i = 1'b0;
        tick();
        pre_to_now_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pre_to_now_valid_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0; excep_i = 1'b0; next_allowin_i = 1'b1;
        excep_flush_i = 1'b0; cache_addr_ok_i = 1'b0; cache_data_ok_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #2;
        checks++; if (cache_req_o !== 1'b0) begin failures++; $display("FAIL reset_req act=%b exp=0", cache_req_o); end
        checks++; if (sent_req_o !== 1'b0) begin failures++; $display("FAIL reset_sent act=%b exp=0", sent_req_o); end
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL reset_tonext act=%b exp=0", now_to_next_valid_o); end
        checks++; if (inflight_num_o !== 2'd0) begin failures++; $display("FAIL reset_inflight act=%0d exp=0", inflight_num_o); end
        checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error act=%b exp=0", error_o); end
        checks++; if (cache_wstrb_o !== 4'b0000) begin failures++; $display("FAIL reset_wstrb act=%b exp=0000", cache_wstrb_o); end
        tick();
    endtask

    task automatic test_store_word;
        load_instr(1'b1, 2'd2, 32'h1000_0004, 32'h1234_5678);
        cache_addr_ok_i = 1'b1; next_allowin_i = 1'b1;
        #2;
        checks++; if (cache_req_o !== 1'b1) begin failures++; $display("FAIL sw_req act=%b exp=1", cache_req_o); end
        checks++; if (cache_wstrb_o !== 4'b1111) begin failures++; $display("FAIL sw_wstrb act=%b exp=1111", cache_wstrb_o); end
        checks++; if (cache_addr_o !== 32'h1000_0004) begin failures++; $display("FAIL sw_addr act=%h exp=10000004", cache_addr_o); end
        checks++; if (cache_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL sw_wdata act=%h exp=12345678", cache_wdata_o); end
        checks++; if (now_clk_pre_cache_req_o !== 1'b1) begin failures++; $display("FAIL sw_accept act=%b exp=1", now_clk_pre_cache_req_o); end
        checks++; if (sent_req_o !== 1'b1) begin failures++; $display("FAIL sw_sent act=%b exp=1", sent_req_o); end
        checks++; if ({now_to_next_valid_o, now_allowin_o} !== 2'b11) begin failures++; $display("FAIL sw_handoff act=%b exp=11", {now_to_next_valid_o, now_allowin_o}); end
        tick();
        cache_addr_ok_i = 1'b0;
        #2;
        checks++; if (inflight_num_o !== 2'd1) begin failures++; $display("FAIL sw_inflight act=%0d exp=1", inflight_num_o); end
        checks++; if (cache_req_o !== 1'b0) begin failures++; $display("FAIL sw_req_after act=%b exp=0", cache_req_o); end
        cache_data_ok_i = 1'b1;
        tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if (inflight_num_o !== 2'd0) begin failures++; $display("FAIL sw_drain act=%0d exp=0", inflight_num_o); end
        tick();
    endtask

    task automatic test_store_sizes;
        load_instr(1'b1, 2'd0, 32'h1000_0003, 32'h0000_00AB);
        cache_addr_ok_i = 1'b1; next_allowin_i = 1'b1;
        #2;
        checks++; if (cache_wstrb_o !== 4'b1000) begin failures++; $display("FAIL sb_wstrb act=%b exp=1000", cache_wstrb_o); end
        checks++; if (cache_wdata_o !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata act=%h exp=abababab", cache_wdata_o); end
        checks++; if (cache_size_o !== 2'd0) begin failures++; $display("FAIL sb_size act=%0d exp=0", cache_size_o); end
        tick();
        load_instr(1'b1, 2'd1, 32'h1000_0002, 32'h0000_BEEF);
        cache_addr_ok_i = 1'b1; cache_data_ok_i = 1'b1;
        #2;
        checks++; if (cache_wstrb_o !== 4'b1100) begin failures++; $display("FAIL sh_wstrb act=%b exp=1100", cache_wstrb_o); end
        checks++; if (cache_wdata_o !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata act=%h exp=beefbeef", cache_wdata_o); end
        tick();
        cache_addr_ok_i = 1'b0;
        #2;
        checks++; if (inflight_num_o !== 2'd1) begin failures++; $display("FAIL sh_inflight act=%0d exp=1", inflight_num_o); end
        cache_data_ok_i = 1'b1;
        tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if (inflight_num_o !== 2'd0) begin failures++; $display("FAIL sh_drain act=%0d exp=0", inflight_num_o); end
        tick();
    endtask

    task automatic test_load_delayed;
        load_instr(1'b0, 2'd2, 32'h2000_0008, 32'hFFFF_FFFF);
        next_allowin_i = 1'b1;
        mem_addr_i = 32'hDEAD_0000;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (cache_req_o !== 1'b1) begin failures++; $display("FAIL ld_hold_req cyc=%0d act=%b exp=1", c, cache_req_o); end
            checks++; if (cache_addr_o !== 32'h2000_0008) begin failures++; $display("FAIL ld_hold_addr cyc=%0d act=%h exp=20000008", c, cache_addr_o); end
            checks++; if (cache_wstrb_o !== 4'b0000) begin failures++; $display("FAIL ld_wstrb cyc=%0d act=%b exp=0000", c, cache_wstrb_o); end
            checks++; if ({now_allowin_o, sent_req_o} !== 2'b00) begin failures++; $display("FAIL ld_stall cyc=%0d act=%b exp=00", c, {now_allowin_o, sent_req_o}); end
            tick();
            mem_addr_i = mem_addr_i + 32'd4;
        end
        cache_addr_ok_i = 1'b1;
        #2;
        checks++; if ({cache_req_o, now_clk_pre_cache_req_o, now_allowin_o} !== 3'b111) begin failures++; $display("FAIL ld_accept act=%b exp=111", {cache_req_o, now_clk_pre_cache_req_o, now_allowin_o}); end
        checks++; if (cache_addr_o !== 32'h2000_0008) begin failures++; $display("FAIL ld_accept_addr act=%h exp=20000008", cache_addr_o); end
        tick();
        cache_addr_ok_i = 1'b0;
        cache_data_ok_i = 1'b1;
        tick();
        cache_data_ok_i = 1'b0;
    endtask

    task automatic test_sent_wait;
        load_instr(1'b1, 2'd2, 32'h4000_0010, 32'hCAFE_F00D);
        cache_addr_ok_i = 1'b1; next_allowin_i = 1'b0;
        #2;
        checks++; if ({sent_req_o, now_to_next_valid_o, now_allowin_o} !== 3'b110) begin failures++; $display("FAIL sent_accept act=%b exp=110", {sent_req_o, now_to_next_valid_o, now_allowin_o}); end
        tick();
        cache_addr_ok_i = 1'b0;
        #2;
        checks++; if ({cache_req_o, sent_req_o, now_to_next_valid_o} !== 3'b011) begin failures++; $display("FAIL sent_hold act=%b exp=011", {cache_req_o, sent_req_o, now_to_next_valid_o}); end
        checks++; if (inflight_num_o !== 2'd1) begin failures++; $display("FAIL sent_inflight act=%0d exp=1", inflight_num_o); end
        next_allowin_i = 1'b1;
        #2;
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL sent_release act=%b exp=1", now_allowin_o); end
        tick();
        cache_data_ok_i = 1'b1;
        #2;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL sent_empty act=%b exp=0", now_to_next_valid_o); end
        tick();
        cache_data_ok_i = 1'b0;
    endtask

    task automatic test_throttle;
        next_allowin_i = 1'b1;
        load_instr(1'b0, 2'd2, 32'h3000_0000, 32'd0);
        cache_addr_ok_i = 1'b1;
        tick();
        load_instr(1'b0, 2'd2, 32'h3000_0004, 32'd0);
        cache_addr_ok_i = 1'b1;
        tick();
        load_instr(1'b0, 2'd2, 32'h3000_0008, 32'd0);
        #2;
        checks++; if (inflight_num_o !== 2'd2) begin failures++; $display("FAIL thr_full act=%0d exp=2", inflight_num_o); end
        checks++; if ({cache_req_o, now_to_next_valid_o, now_allowin_o} !== 3'b000) begin failures++; $display("FAIL thr_block act=%b exp=000", {cache_req_o, now_to_next_valid_o, now_allowin_o}); end
        tick();
        cache_data_ok_i = 1'b1;
        #2;
        checks++; if (cache_req_o !== 1'b0) begin failures++; $display("FAIL thr_same_cycle act=%b exp=0", cache_req_o); end
        tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if ({cache_req_o, inflight_num_o} !== 3'b101) begin failures++; $display("FAIL thr_unblock act=%b exp=101", {cache_req_o, inflight_num_o}); end
        cache_addr_ok_i = 1'b1;
        tick();
        cache_addr_ok_i = 1'b0;
        #2;
        checks++; if (inflight_num_o !== 2'd2) begin failures++; $display("FAIL thr_refill act=%0d exp=2", inflight_num_o); end
        cache_data_ok_i = 1'b1;
        tick(); tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if ({inflight_num_o, error_o} !== 3'b000) begin failures++; $display("FAIL thr_drain act=%b exp=000", {inflight_num_o, error_o}); end
        tick();
    endtask

    task automatic test_flush;
        next_allowin_i = 1'b1;
        load_instr(1'b0, 2'd2, 32'h5000_0000, 32'd0);
        cache_addr_ok_i = 1'b1;
        tick();
        load_instr(1'b1, 2'd2, 32'h5000_0004, 32'h1111_2222);
        tick();
        excep_flush_i = 1'b1;
        #2;
        checks++; if ({cache_req_o, now_clk_pre_cache_req_o, now_to_next_valid_o} !== 3'b000) begin failures++; $display("FAIL fl_withdraw act=%b exp=000", {cache_req_o, now_clk_pre_cache_req_o, now_to_next_valid_o}); end
        tick();
        excep_flush_i = 1'b0;
        #2;
        checks++; if ({cache_req_o, now_to_next_valid_o} !== 2'b00) begin failures++; $display("FAIL fl_empty act=%b exp=00", {cache_req_o, now_to_next_valid_o}); end
        checks++; if (inflight_num_o !== 2'd1) begin failures++; $display("FAIL fl_inflight act=%0d exp=1", inflight_num_o); end
        cache_data_ok_i = 1'b1;
        tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if ({inflight_num_o, error_o} !== 3'b000) begin failures++; $display("FAIL fl_drain act=%b exp=000", {inflight_num_o, error_o}); end
        tick();
    endtask

    task automatic test_error;
        cache_data_ok_i = 1'b1;
        tick();
        cache_data_ok_i = 1'b0;
        #2;
        checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL err_set act=%b exp=1", error_o); end
        checks++; if (inflight_num_o !== 2'd0) begin failures++; $display("FAIL err_inflight act=%0d exp=0", inflight_num_o); end
        tick(); tick(); tick();
        checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL err_sticky act=%b exp=1", error_o); end
    endtask

    task automatic test_reset_mid_req;
        next_allowin_i = 1'b1;
        load_instr(1'b1, 2'd2, 32'h6000_0000, 32'h5555_AAAA);
        mem_addr_i = 32'h0;
        tick();
        #2;
        checks++; if (cache_req_o !== 1'b1) begin failures++; $display("FAIL rst_mid_pre act=%b exp=1", cache_req_o); end
        rst = 1'b1;
        #1;
        checks++; if ({cache_req_o, sent_req_o, now_to_next_valid_o, error_o} !== 4'b0000) begin failures++; $display("FAIL rst_mid_ctl act=%b exp=0000", {cache_req_o, sent_req_o, now_to_next_valid_o, error_o}); end
        checks++; if ({cache_addr_o, cache_wstrb_o, inflight_num_o} !== 38'd0) begin failures++; $display("FAIL rst_mid_data act=%h exp=0", {cache_addr_o, cache_wstrb_o, inflight_num_o}); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sizes();
        test_load_delayed();
        test_sent_wait();
        test_throttle();
        test_flush();
        test_error();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
